quickq_ring: RTL and testbench
==============================

Name: quickq_ring

Overview:
- Parametrised successor to the single-cycle PQ: a sorted priority queue held in one dual-port BRAM organised as a circular buffer (head/tail pointers).
- Dequeue is O(1): head pointer advance plus head refresh. Enqueue is an insertion-sort scan from tail toward head, shifting one entry per cycle.
- Adds configurable min/max ordering, stable ordering among equal keys, replace (simultaneous enq+deq), a size output and a drop pulse.
- Sits behind the pq_if-style testbench and driver as a drop-in PQ with a busy handshake.

Parameters:
- KEY_WIDTH, 8, key bits.
- VAL_WIDTH, 8, value bits.
- CAPACITY, 16, maximum entries (>=2, need not be a power of two).
- MAX_FIRST, 0, 0 = smallest key at head, 1 = largest key at head.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- enq  in  1  enqueue request, sampled only when busy=0.
- deq  in  1  dequeue request, sampled only when busy=0.
- key_in  in  KEY_WIDTH  key to insert.
- val_in  in  VAL_WIDTH  value to insert.
- key_out  out  KEY_WIDTH  head key, registered.
- val_out  out  VAL_WIDTH  head value, registered.
- full  out  1  size==CAPACITY.
- empty  out  1  size==0.
- busy  out  1  operation in progress; requests ignored.
- size  out  $clog2(CAPACITY+1)  current entry count.
- drop  out  1  one-cycle pulse: enq (without deq) requested while full and idle.

Behaviour:
- Reset (rst==0 at a clk edge) has priority over everything, including mid-operation:
  - state IDLE; head=tail=size=0; key_out=val_out=0; busy=0; drop=0; empty=1; full=0.
  - BRAM contents are not cleared.
- Storage: mem2p_sw_sr, depth CAPACITY, 1-cycle synchronous read.
  - Pointers increment/decrement modulo CAPACITY with explicit wrap (CAPACITY-1 -> 0, 0 -> CAPACITY-1).
- "beats(a,b)": a.key<b.key if MAX_FIRST=0, a.key>b.key if MAX_FIRST=1.
  - Strict comparison, so equal keys keep FIFO order (a new entry goes behind existing equals).
- Request decode in IDLE. Cycle 0 is the accept edge:
  - enq&deq&!empty -> REPLACE.
  - enq&!full -> ENQ.
  - deq&!empty -> DEQ.
  - enq&full without deq -> drop pulse next cycle, state unchanged.
  - deq&empty -> ignored silently.
- DEQ: head<=head+1, size<=size-1.
  - If new size==0: return to IDLE; busy low at cycle 1; key_out/val_out hold stale data.
  - Otherwise go to REFRESH.
- ENQ into empty: write kvi at tail, tail++, size++, go to REFRESH.
- ENQ non-empty: latch kvi into temp; ptr<=tail-1; issue read ptr; go to SCAN.
- SCAN (dout = mem[ptr]):
  - If beats(temp,dout): write dout at ptr+1.
    - If ptr==head: go to PLACE.
    - Else ptr--, issue read ptr-1, stay in SCAN.
  - Else: write temp at ptr+1, go to FIN.
  - The read address and write address in the same cycle never coincide.
- PLACE: write temp at head, go to FIN.
- FIN: tail++, size++, go to REFRESH.
  - To meet the latency below, FIN is folded into the final SCAN/PLACE cycle.
- REFRESH: issue read of mem[head], go to LOAD.
- LOAD: key_out/val_out <= dout, go to IDLE.
- REPLACE: head<=head+1 (size unchanged), then identical to ENQ, comparing against the new head.
  - If the old size was 1, it behaves as ENQ into empty at the new head/tail.
  - Legal when full.
- Latency (accept at cycle 0; busy=0 and outputs updated at cycle L):
  - DEQ leaving entries: L=3.
  - DEQ to empty: L=1.
  - ENQ into empty: L=3.
  - ENQ/REPLACE that shifts k entries: L=k+4.
- busy is high from cycle 1 up to cycle L-1.
- full, empty and size update on the edge where the pointer changes.

Decomposition:
- pq_pkg additions:
  - quickq_ring state enum (IDLE, SCAN, PLACE, REFRESH, LOAD).
  - Default KEY_WIDTH/VAL_WIDTH/CAPACITY constants.
- kv_t stays in pq_pkg; this block uses its own parametrised struct locally.
- Sub-modules: reuse the existing mem2p_sw_sr. One new sub-module, quickq_ring_ctrl (FSM plus pointers), is natural.
- Datapath registers (temp, key_out/val_out) live in the top level.

Test Plan (CAPACITY=4, MAX_FIRST=0 unless stated):
- Reset held low 2 cycles mid-SCAN -> busy=0, empty=1, size=0, key_out=0 next cycle; subsequent enq key 5 gives key_out=5 at L=3.
- Enq keys 7,3,9,1 (wait for !busy each time) -> key_out 7,3,3,1; full=1; per-op latencies 3,5,4,7 cycles.
- With full {1,3,7,9}: enq 2 -> drop pulse for 1 cycle, contents unchanged. Then deq x4 -> key_out 3,7,9 then empty=1 at L=1.
- Equal keys: enq (4,val A), (4,val B), then deq twice -> val_out A, then B.
- Wrap: enq/deq alternately 10 times so head passes index 3->0 -> order preserved, size correct, no stale data at key_out.
- REPLACE on full {2,4,6,8} with key 5 -> head 4, contents {4,5,6,8}, size=4. MAX_FIRST=1 build: enq 3,8,5 -> key_out 8.

Source files
------------

// File: rtl/quickq_ring_pkg.sv
// Shared constants and enums for the quickq_ring sorted priority queue.
package quickq_ring_pkg;
  localparam int QQ_KEY_WIDTH = 8;
  localparam int QQ_VAL_WIDTH = 8;
  localparam int QQ_CAPACITY  = 16;

  typedef enum logic [2:0] {QQ_IDLE, QQ_SCAN, QQ_PLACE, QQ_REFRESH, QQ_LOAD} qq_state_e;
  typedef enum logic [1:0] {WSEL_IN, WSEL_TMP, WSEL_DOUT} qq_wsel_e;
endpackage

// File: rtl/mem2p_sw_sr.sv
// Two-port RAM: one synchronous write port, one registered read port.
module mem2p_sw_sr #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/quickq_ring_ctrl.sv
// FSM and ring pointers for quickq_ring; drives RAM addresses and datapath strobes.
module quickq_ring_ctrl
  import quickq_ring_pkg::*;
#(
  parameter  int CAPACITY = QQ_CAPACITY,
  localparam int PW       = $clog2(CAPACITY),
  localparam int SW       = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic          deq_i,
  input  logic          beats_i,
  output logic          busy_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o,
  output logic [SW-1:0] size_o,
  output logic          we_o,
  output logic [PW-1:0] waddr_o,
  output logic [PW-1:0] raddr_o,
  output logic [1:0]    wsel_o,
  output logic          tmp_ld_o,
  output logic          out_ld_o
);
  qq_state_e     state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, ptr_q, ptr_d;
  logic [SW-1:0] size_q, size_d;
  logic          rep_q, rep_d, drop_q, drop_d;
  logic          full_w, empty_w;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(CAPACITY - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(CAPACITY - 1) : p - PW'(1);
  endfunction

  assign full_w  = (size_q == SW'(CAPACITY));
  assign empty_w = (size_q == '0);

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    ptr_d    = ptr_q;
    size_d   = size_q;
    rep_d    = rep_q;
    drop_d   = 1'b0;
    we_o     = 1'b0;
    waddr_o  = tail_q;
    raddr_o  = head_q;
    wsel_o   = WSEL_IN;
    tmp_ld_o = 1'b0;
    out_ld_o = 1'b0;
    unique case (state_q)
      QQ_IDLE: begin
        // Prefetch the tail entry so the first scan compare is ready next cycle.
        raddr_o = dec(tail_q);
        if (enq_i && deq_i && !empty_w) begin
          head_d = inc(head_q);
          rep_d  = 1'b1;
          if (size_q == SW'(1)) begin
            we_o    = 1'b1;
            tail_d  = inc(tail_q);
            state_d = QQ_REFRESH;
          end else begin
            tmp_ld_o = 1'b1;
            ptr_d    = dec(tail_q);
            state_d  = QQ_SCAN;
          end
        end else if (enq_i && !full_w) begin
          rep_d = 1'b0;
          if (empty_w) begin
            we_o    = 1'b1;
            tail_d  = inc(tail_q);
            size_d  = size_q + SW'(1);
            state_d = QQ_REFRESH;
          end else begin
            tmp_ld_o = 1'b1;
            ptr_d    = dec(tail_q);
            state_d  = QQ_SCAN;
          end
        end else if (deq_i && !empty_w) begin
          head_d  = inc(head_q);
          size_d  = size_q - SW'(1);
          state_d = (size_q == SW'(1)) ? QQ_IDLE : QQ_REFRESH;
        end else if (enq_i && full_w) begin
          drop_d = 1'b1;
        end
      end
      QQ_SCAN: begin
        we_o    = 1'b1;
        waddr_o = inc(ptr_q);
        if (beats_i) begin
          wsel_o = WSEL_DOUT;
          if (ptr_q == head_q) begin
            state_d = QQ_PLACE;
          end else begin
            ptr_d   = dec(ptr_q);
            raddr_o = dec(ptr_q);
          end
        end else begin
          wsel_o  = WSEL_TMP;
          tail_d  = inc(tail_q);
          size_d  = rep_q ? size_q : size_q + SW'(1);
          state_d = QQ_REFRESH;
        end
      end
      QQ_PLACE: begin
        we_o    = 1'b1;
        waddr_o = head_q;
        wsel_o  = WSEL_TMP;
        tail_d  = inc(tail_q);
        size_d  = rep_q ? size_q : size_q + SW'(1);
        state_d = QQ_REFRESH;
      end
      QQ_REFRESH: begin
        raddr_o = head_q;
        state_d = QQ_LOAD;
      end
      QQ_LOAD: begin
        out_ld_o = 1'b1;
        state_d  = QQ_IDLE;
      end
      default: state_d = QQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= QQ_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      ptr_q   <= '0;
      size_q  <= '0;
      rep_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ptr_q   <= ptr_d;
      size_q  <= size_d;
      rep_q   <= rep_d;
      drop_q  <= drop_d;
    end
  end

  assign busy_o  = (state_q != QQ_IDLE);
  assign full_o  = full_w;
  assign empty_o = empty_w;
  assign drop_o  = drop_q;
  assign size_o  = size_q;
endmodule

// File: rtl/quickq_ring.sv
// Sorted priority queue in a circular RAM: O(1) dequeue, insertion-sort enqueue.
module quickq_ring
  import quickq_ring_pkg::*;
#(
  parameter int KEY_WIDTH = QQ_KEY_WIDTH,
  parameter int VAL_WIDTH = QQ_VAL_WIDTH,
  parameter int CAPACITY  = QQ_CAPACITY,
  parameter int MAX_FIRST = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq,
  input  logic                           deq,
  input  logic [KEY_WIDTH-1:0]           key_in,
  input  logic [VAL_WIDTH-1:0]           val_in,
  output logic [KEY_WIDTH-1:0]           key_out,
  output logic [VAL_WIDTH-1:0]           val_out,
  output logic                           full,
  output logic                           empty,
  output logic                           busy,
  output logic [$clog2(CAPACITY+1)-1:0]  size,
  output logic                           drop
);
  localparam int PW = $clog2(CAPACITY);

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  kv_t           kvi, dout, wdata, tmp_q, out_q;
  logic          beats, we, tmp_ld, out_ld;
  logic [PW-1:0] waddr, raddr;
  logic [1:0]    wsel;

  assign kvi = '{key: key_in, val: val_in};

  // Strict compare keeps equal keys in arrival order.
  assign beats = (MAX_FIRST != 0) ? (tmp_q.key > dout.key) : (tmp_q.key < dout.key);

  always_comb begin
    wdata = kvi;
    if (wsel == WSEL_TMP)  wdata = tmp_q;
    if (wsel == WSEL_DOUT) wdata = dout;
  end

  quickq_ring_ctrl #(.CAPACITY(CAPACITY)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .enq_i    (enq),
    .deq_i    (deq),
    .beats_i  (beats),
    .busy_o   (busy),
    .full_o   (full),
    .empty_o  (empty),
    .drop_o   (drop),
    .size_o   (size),
    .we_o     (we),
    .waddr_o  (waddr),
    .raddr_o  (raddr),
    .wsel_o   (wsel),
    .tmp_ld_o (tmp_ld),
    .out_ld_o (out_ld)
  );

  mem2p_sw_sr #(.DEPTH(CAPACITY), .WIDTH(KEY_WIDTH + VAL_WIDTH)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (dout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmp_q <= '0;
      out_q <= '0;
    end else begin
      if (tmp_ld) tmp_q <= kvi;
      if (out_ld) out_q <= dout;
    end
  end

  assign key_out = out_q.key;
  assign val_out = out_q.val;
endmodule

// File: tb/tb_quickq_ring.sv
// Directed scoreboard bench for quickq_ring: min-first and max-first builds, CAPACITY=4.
module tb_quickq_ring;
  localparam int CAP = 4;
  localparam int SW  = $clog2(CAP + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] enq, deq;
  logic [7:0] key_in, val_in;
  logic [7:0] ko [2];
  logic [7:0] vo [2];
  logic [SW-1:0] sz [2];
  logic full_w [2], empty_w [2], busy_w [2], drop_w [2];

  always #5 clk = ~clk;

  quickq_ring #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CAPACITY(CAP), .MAX_FIRST(0)) u_min (
    .clk(clk), .rst(rst), .enq(enq[0]), .deq(deq[0]), .key_in(key_in), .val_in(val_in),
    .key_out(ko[0]), .val_out(vo[0]), .full(full_w[0]), .empty(empty_w[0]),
    .busy(busy_w[0]), .size(sz[0]), .drop(drop_w[0]));

  quickq_ring #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CAPACITY(CAP), .MAX_FIRST(1)) u_max (
    .clk(clk), .rst(rst), .enq(enq[1]), .deq(deq[1]), .key_in(key_in), .val_in(val_in),
    .key_out(ko[1]), .val_out(vo[1]), .full(full_w[1]), .empty(empty_w[1]),
    .busy(busy_w[1]), .size(sz[1]), .drop(drop_w[1]));

  typedef struct packed { logic [7:0] k; logic [7:0] v; } kv_t;
  typedef struct { int lat; int sz; int ko; int vo; int drop; } exp_t;

  kv_t  mdl[$];
  exp_t sb[$];
  int   ek = 0, ev = 0;
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference insert: new entry goes behind every entry it does not strictly beat.
  task automatic m_ins(input kv_t x, input bit mx, output int shifted);
    int i = 0;
    while (i < mdl.size() && !(mx ? (x.k > mdl[i].k) : (x.k < mdl[i].k))) i++;
    mdl.insert(i, x);
    shifted = mdl.size() - 1 - i;
  endtask

  task automatic op(input int s, input bit e, input bit d, input int k, input int v,
                    input string tag);
    exp_t x;
    int   sh, n;
    bit   was;
    logic drp;
    kv_t  item;
    item = '{k: k[7:0], v: v[7:0]};
    @(negedge clk);
    enq[s] = e; deq[s] = d; key_in = k[7:0]; val_in = v[7:0];
    x.drop = 0;
    if (e && d && mdl.size() > 0) begin
      was = (mdl.size() == 1);
      void'(mdl.pop_front());
      m_ins(item, s[0], sh);
      x.lat = was ? 3 : sh + 4;
    end else if (e && mdl.size() < CAP) begin
      was = (mdl.size() == 0);
      m_ins(item, s[0], sh);
      x.lat = was ? 3 : sh + 4;
    end else if (d && mdl.size() > 0) begin
      void'(mdl.pop_front());
      x.lat = (mdl.size() == 0) ? 1 : 3;
    end else begin
      x.lat  = 1;
      x.drop = e ? 1 : 0;
    end
    if (mdl.size() > 0) begin ek = int'(mdl[0].k); ev = int'(mdl[0].v); end
    x.sz = mdl.size(); x.ko = ek; x.vo = ev;
    sb.push_back(x);
    @(negedge clk);
    enq[s] = 1'b0; deq[s] = 1'b0;
    n = 1;
    drp = drop_w[s];
    while (busy_w[s] && n < 60) begin @(negedge clk); n++; end
    x = sb.pop_front();
    chk($sformatf("%s_lat", tag),   32'(n),          32'(x.lat));
    chk($sformatf("%s_drop", tag),  32'(drp),        32'(x.drop));
    chk($sformatf("%s_key", tag),   32'(ko[s]),      32'(x.ko));
    chk($sformatf("%s_val", tag),   32'(vo[s]),      32'(x.vo));
    chk($sformatf("%s_size", tag),  32'(sz[s]),      32'(x.sz));
    chk($sformatf("%s_full", tag),  32'(full_w[s]),  32'(x.sz == CAP));
    chk($sformatf("%s_empty", tag), 32'(empty_w[s]), 32'(x.sz == 0));
  endtask

  initial begin
    enq = '0; deq = '0; key_in = '0; val_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy",  32'(busy_w[0]),  32'd0);
    chk("rst_empty", 32'(empty_w[0]), 32'd1);
    chk("rst_full",  32'(full_w[0]),  32'd0);
    chk("rst_size",  32'(sz[0]),      32'd0);
    chk("rst_key",   32'(ko[0]),      32'd0);
    chk("rst_drop",  32'(drop_w[0]),  32'd0);

    op(0, 1, 0, 7, 8'h70, "enq7");
    op(0, 1, 0, 3, 8'h30, "enq3");
    op(0, 1, 0, 9, 8'h90, "enq9");
    op(0, 1, 0, 1, 8'h10, "enq1");
    op(0, 1, 0, 2, 8'h20, "drop2");
    for (int i = 0; i < 4; i++) op(0, 0, 1, 0, 0, "deq_full");
    op(0, 0, 1, 0, 0, "deq_empty");

    op(0, 1, 0, 4, 8'hA, "eqA");
    op(0, 1, 0, 4, 8'hB, "eqB");
    op(0, 0, 1, 0, 0, "eq_deq1");
    op(0, 0, 1, 0, 0, "eq_deq2");

    op(0, 1, 0, 50, 8'h55, "wrap_seed");
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) op(0, 1, 0, (i * 7) % 20 + 1, i + 1, "wrap_enq");
      else            op(0, 0, 1, 0, 0, "wrap_deq");
    end
    while (mdl.size() > 0) op(0, 0, 1, 0, 0, "wrap_drain");

    op(0, 1, 0, 8, 8'h80, "r_enq8");
    op(0, 1, 0, 6, 8'h60, "r_enq6");
    op(0, 1, 0, 4, 8'h40, "r_enq4");
    op(0, 1, 0, 2, 8'h20, "r_enq2");
    op(0, 1, 1, 5, 8'h50, "replace5");
    while (mdl.size() > 0) op(0, 0, 1, 0, 0, "r_drain");

    op(1, 1, 0, 3, 8'h33, "max3");
    op(1, 1, 0, 8, 8'h88, "max8");
    op(1, 1, 0, 5, 8'h55, "max5");
    mdl.delete();

    op(0, 1, 0, 9, 8'h99, "s_enq9");
    op(0, 1, 0, 8, 8'h88, "s_enq8");
    op(0, 1, 0, 7, 8'h77, "s_enq7");
    @(negedge clk);
    enq[0] = 1'b1; key_in = 8'd1; val_in = 8'd1;
    @(negedge clk);
    enq[0] = 1'b0;
    chk("scan_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("mrst_busy",  32'(busy_w[0]),  32'd0);
    chk("mrst_empty", 32'(empty_w[0]), 32'd1);
    chk("mrst_size",  32'(sz[0]),      32'd0);
    chk("mrst_key",   32'(ko[0]),      32'd0);
    mdl.delete(); ek = 0; ev = 0;
    op(0, 1, 0, 5, 8'h5A, "post_rst5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
